pb_debouncer: RTL and testbench
===============================

# pb_debouncer

Push-button debouncer: synchronizes a raw mechanical button input into the clock domain and only propagates a level change after it has been stable for a programmable number of clock cycles. It sits between board pins and user logic, for example the PWM duty-control buttons, and delivers a clean level signal. Top-level module name is `pb_debouncer`.

## Interface
- `STABLE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive cycles the synchronized input must differ from `pb_out` before `pb_out` updates; legal range ≥ 1.
- `clk`, input, 1: system clock (50 MHz nominal, 20 ns period); all logic on the rising edge.
- `rst`, input, 1: one clock domain. Reset is asynchronous and active-low.
- `pb_in`, input, 1: raw, asynchronous, bouncing button level.
- `pb_out`, output, 1: debounced level, registered.
- `pb_rise`, output, 1: one-cycle pulse on a 0→1 change of `pb_out`. Present only with `PB_DEBOUNCER_EDGE_EN`.
- `pb_fall`, output, 1: one-cycle pulse on a 1→0 change of `pb_out`. Present only with `PB_DEBOUNCER_EDGE_EN`.

## Operation
- Two-flop synchronizer: `pb_in` → `s1` → `s2`. Only `s2` is used downstream.
- Counter `cnt`, width `CNT_W = max(1, $clog2(STABLE_CYCLES))`.
- Each rising edge:
  - If `s2 == pb_out`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `pb_out <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Any return of `s2` to the `pb_out` value before the threshold discards the count (restart from 0). Bounces shorter than `STABLE_CYCLES` never reach `pb_out`.
- The counter never wraps, because it is cleared at the threshold.
- Unknown or undriven `pb_in` before first drive: the synchronizer holds its reset value 0. No special handling is required.

## Timing
- Reset (`rst` low, asynchronous): `s1 = s2 = 0`, `cnt = 0`, `pb_out = 0`, `pb_rise = pb_fall = 0`. Deassertion takes effect on the next rising edge.
- Latency: a new `pb_in` level first sampled at edge N and held stable changes `pb_out` at edge N + STABLE_CYCLES + 1. That is the (STABLE_CYCLES+2)-th edge counting edge N as the first.
- `STABLE_CYCLES = 1`: `pb_out` follows `pb_in` with a pure 3-edge delay, counting the sampling edge.
- Edge pulses are asserted in the same cycle `pb_out` changes, for exactly one cycle.
- Reset asserted mid-count: the count is lost and `pb_out` returns to 0 immediately.
- Input held at 1 through reset release: `pb_out` rises STABLE_CYCLES+2 edges after release.

## Configuration
- `PB_DEBOUNCER_EDGE_EN` defined: adds `pb_rise`/`pb_fall` ports. Each is a registered compare of the next `pb_out` value against the current one, reset to 0.
- Not defined: ports and logic are absent; the module has only `clk`, `rst`, `pb_in` and `pb_out`.

## Structure
- Package `pb_debouncer_pkg` holds:
  - `DEFAULT_STABLE_CYCLES` (1_000_000) and `CLK_FREQ_HZ` (50_000_000).
  - Function `cnt_width(int n)` returning `max(1, $clog2(n))`.
  - Typedef `pb_level_t` (1-bit logic).
- Sub-module `sync_2ff` (parameter-free 2-flop synchronizer, async active-low reset to 0), instantiated once.
- Counter and output register live in `pb_debouncer`.

## Test plan
Bench settings: 50 MHz clock, `STABLE_CYCLES = 8`.
- Reset: hold `rst = 0` for 5 cycles with `pb_in = 1` → `pb_out = 0` and `cnt = 0` throughout reset.
- Bounce rejection: toggle `pb_in` every 100 ns (5 cycles) six times → `pb_out` stays 0; no `pb_rise` pulse.
- Clean press: `pb_in` 0→1 and hold 20 cycles → `pb_out` rises exactly at the 10th edge after the first sampling edge. With the macro, `pb_rise` is high for that single cycle.
- Clean release: `pb_in` 1→0 held → `pb_out` falls after 10 edges. With the macro, `pb_fall` pulses once.
- Glitch restart: hold high 6 cycles, low 1 cycle, then high → `pb_out` rises 10 edges after the final rising sample, not earlier.
- Reset mid-count: assert `rst` at count 5 with `pb_in = 1`, then release → `pb_out = 0` immediately, then rises 10 edges after release.

Source files
------------

// File: rtl/pb_debouncer_pkg.sv
// Shared constants, types and helpers for the push-button debouncer.
package pb_debouncer_pkg;

   localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;
   localparam int unsigned CLK_FREQ_HZ           = 50_000_000;

   typedef logic pb_level_t;

   // Counter width: never narrower than one bit, even for a threshold of 1.
   function automatic int unsigned cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : int'(w);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic s1_d, s1_q;
   logic s2_d, s2_q;

   always_comb begin
      s1_d = d_i;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizes pb_in and updates pb_out only after a stable run.
// Define PB_DEBOUNCER_EDGE_EN to add the registered pb_rise/pb_fall pulse outputs.
module pb_debouncer
   import pb_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_in,
`ifdef PB_DEBOUNCER_EDGE_EN
   output logic pb_out,
   output logic pb_rise,
   output logic pb_fall
`else
   output logic pb_out
`endif
);

   localparam int unsigned     CNT_W   = cnt_width(int'(STABLE_CYCLES));
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   pb_level_t        pb_sync;
   pb_level_t        pb_out_d, pb_out_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pb_in),
      .q_o (pb_sync)
   );

   // Any sample matching pb_out discards the run; the count is cleared at the threshold.
   always_comb begin
      pb_out_d = pb_out_q;
      cnt_d    = cnt_q;
      if (pb_sync == pb_out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         pb_out_d = pb_sync;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pb_out_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pb_out_q <= pb_out_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pb_out = pb_out_q;

`ifdef PB_DEBOUNCER_EDGE_EN
   logic pb_rise_d, pb_rise_q;
   logic pb_fall_d, pb_fall_q;

   // Pulses register alongside pb_out so they coincide with its change.
   always_comb begin
      pb_rise_d = pb_out_d & ~pb_out_q;
      pb_fall_d = ~pb_out_d & pb_out_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pb_rise_q <= 1'b0;
         pb_fall_q <= 1'b0;
      end else begin
         pb_rise_q <= pb_rise_d;
         pb_fall_q <= pb_fall_d;
      end
   end

   assign pb_rise = pb_rise_q;
   assign pb_fall = pb_fall_q;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Bench for pb_debouncer with STABLE_CYCLES = 8; window-based reference model plus scoreboard.
// Checks pb_rise/pb_fall as well when PB_DEBOUNCER_EDGE_EN is defined.
`timescale 1ns/1ps
module tb_pb_debouncer;

   localparam int unsigned S = 8;

   logic clk;
   logic rst;
   logic pb_in;
   logic pb_out;
`ifdef PB_DEBOUNCER_EDGE_EN
   logic pb_rise;
   logic pb_fall;
`endif

   pb_debouncer #(
      .STABLE_CYCLES (S)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pb_in  (pb_in),
`ifdef PB_DEBOUNCER_EDGE_EN
      .pb_out  (pb_out),
      .pb_rise (pb_rise),
      .pb_fall (pb_fall)
`else
      .pb_out (pb_out)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic out;
      logic rise;
      logic fall;
      logic in_reset;
   } exp_t;

   typedef struct {
      logic rst_v;
      logic in;
      int   hold;
      logic exp_end;
   } vec_t;

   exp_t exp_q[$];
   exp_t cur;
   vec_t vecs[$];
   int   n_pass;
   int   n_total;

   // Reference model: pb_in samples, newest last; the decision at an edge looks at the S
   // samples taken from two to S+1 edges earlier and needs all of them to differ from pb_out.
   logic hist[$];
   logic m_out;

   task automatic check(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < int'(S) + 2; i++) hist.push_back(1'b0);
      m_out = 1'b0;
   endtask

   task automatic model_edge(input logic x, output exp_t e);
      logic all_diff;
      logic old;
      hist.push_back(x);
      all_diff = 1'b1;
      for (int i = 1; i <= int'(S); i++) if (hist[i] == m_out) all_diff = 1'b0;
      old = m_out;
      if (all_diff) m_out = hist[S];
      void'(hist.pop_front());
      e.out      = m_out;
      e.rise     = m_out & ~old;
      e.fall     = ~m_out & old;
      e.in_reset = 1'b0;
   endtask

   task automatic step(input logic r, input logic in);
      exp_t e;
      @(negedge clk);
      #2;
      rst   = r;
      pb_in = in;
      if (!r) begin
         #1;
         check("async_reset_out", pb_out, 1'b0);
         model_reset();
      end
      @(posedge clk);
      #1;
      if (r) begin
         model_edge(in, e);
      end else begin
         e.out      = 1'b0;
         e.rise     = 1'b0;
         e.fall     = 1'b0;
         e.in_reset = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("pb_out", pb_out, cur.out);
`ifdef PB_DEBOUNCER_EDGE_EN
         check("pb_rise", pb_rise, cur.rise);
         check("pb_fall", pb_fall, cur.fall);
`endif
         if (cur.in_reset) check("cnt_zero_in_reset", (dut.cnt_q == '0), 1'b1);
      end
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b0;
      pb_in   = 1'b1;
      model_reset();

      vecs.push_back('{1'b0, 1'b1, 5, 1'b0});   // reset with button held
      vecs.push_back('{1'b1, 1'b0, 5, 1'b0});
      for (int i = 0; i < 3; i++) begin          // bounce every 5 cycles
         vecs.push_back('{1'b1, 1'b1, 5, 1'b0});
         vecs.push_back('{1'b1, 1'b0, 5, 1'b0});
      end
      vecs.push_back('{1'b1, 1'b1, 20, 1'b1});  // clean press
      vecs.push_back('{1'b1, 1'b0, 20, 1'b0});  // clean release
      vecs.push_back('{1'b1, 1'b1, 6, 1'b0});   // glitch restart
      vecs.push_back('{1'b1, 1'b0, 1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 9, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 20, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 7, 1'b0});   // reset mid-count (count 5)
      vecs.push_back('{1'b0, 1'b1, 2, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 9, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1, 1'b0});   // reset while pb_out is high
      vecs.push_back('{1'b1, 1'b0, 12, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8, 1'b0});   // one short of the threshold
      vecs.push_back('{1'b1, 1'b1, 1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1, 1'b1});

      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].hold; c++) step(vecs[i].rst_v, vecs[i].in);
         #1;
         check("segment_end_out", pb_out, vecs[i].exp_end);
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", (exp_q.size() == 0), 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
